// File: rtl/mem_responder.sv
// Memory-side responder: one request per cycle, fixed one-cycle acknowledge,
// write storage with per-word written flags so reads never return unknown data.
module mem_responder #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  valid,
  input  logic                  wr_rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic                  ready,
  output logic [WIDTH-1:0]      rdata,
  output logic                  err,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];

  typedef enum logic {IDLE, ACK} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] written;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             do_wr, do_rd;

  assign in_range = ({1'b0, addr} < DEPTH_L);
  assign idx      = addr[IDX_W-1:0];
  assign do_wr    = valid && wr_rd && in_range;
  assign do_rd    = valid && !wr_rd && in_range;

  always_ff @(posedge clk or posedge res) begin
    if (res) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid) state_d = ACK;
      end
      ACK: begin
        ready = 1'b1;
        if (!valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage has no reset; the written flags stand in for initial contents.
  always_ff @(posedge clk) begin
    if (!res && do_wr) mem[idx] <= wdata;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      written  <= '0;
      rdata    <= '0;
      err      <= 1'b0;
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      err <= valid && !in_range;
      if (do_wr) begin
        written[idx] <= 1'b1;
        if (wr_count != '1) wr_count <= wr_count + 1'b1;
      end
      if (do_rd) begin
        rdata <= written[idx] ? mem[idx] : '0;
        if (rd_count != '1) rd_count <= rd_count + 1'b1;
      end else if (valid && !wr_rd) begin
        rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (DEPTH=12, CNT_WIDTH=4 to reach range and saturation edges).
module tb_mem_responder;

  logic       clk;
  logic       res;
  logic       valid;
  logic       wr_rd;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic       ready;
  logic [7:0] rdata;
  logic       err;
  logic [3:0] wr_count;
  logic [3:0] rd_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  mem_responder #(
    .WIDTH(8),
    .ADDR_WIDTH(4),
    .DEPTH(12),
    .CNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .res(res),
    .valid(valid),
    .wr_rd(wr_rd),
    .addr(addr),
    .wdata(wdata),
    .ready(ready),
    .rdata(rdata),
    .err(err),
    .wr_count(wr_count),
    .rd_count(rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request (or idle) for a single edge, then settle 1 time unit past it.
  task automatic step(input logic v, input logic w, input logic [3:0] a, input logic [7:0] d);
    valid = v;
    wr_rd = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned exp_wr;
    int unsigned exp_rd;

    res = 1'b1; valid = 1'b1; wr_rd = 1'b1; addr = 4'd3; wdata = 8'h77;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_err",   32'(err),   32'd0);
    check("rst_wrcnt", 32'(wr_count), 32'd0);
    check("rst_rdcnt", 32'(rd_count), 32'd0);

    res = 1'b0;
    step(1'b1, 1'b0, 4'd3, 8'h00);
    check("rel_ready", 32'(ready), 32'd1);
    check("rel_rdata", 32'(rdata), 32'd0);
    check("rel_rdcnt", 32'(rd_count), 32'd1);
    check("rel_wrcnt", 32'(wr_count), 32'd0);
    step(1'b0, 1'b0, 4'd0, 8'h00);
    check("idle_ready", 32'(ready), 32'd0);

    step(1'b1, 1'b1, 4'd2, 8'hA5);
    check("wr_ready", 32'(ready), 32'd1);
    check("wr_wrcnt", 32'(wr_count), 32'd1);
    check("wr_rdata_hold", 32'(rdata), 32'd0);
    step(1'b1, 1'b0, 4'd2, 8'h00);
    check("rd_ready", 32'(ready), 32'd1);
    check("rd_rdata", 32'(rdata), 32'hA5);
    check("rd_rdcnt", 32'(rd_count), 32'd2);
    step(1'b0, 1'b0, 4'd0, 8'h00);
    check("rd_idle_ready", 32'(ready), 32'd0);
    check("rd_idle_hold", 32'(rdata), 32'hA5);

    exp_wr = 1;
    exp_rd = 2;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 4'(i), 8'(8'h10 + i));
      exp_wr++;
      check("burst_wr_ready", 32'(ready), 32'd1);
      check("burst_wrcnt", 32'(wr_count), exp_wr);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 4'(i), 8'h00);
      exp_rd++;
      check("burst_rd_ready", 32'(ready), 32'd1);
      check("burst_rdata", 32'(rdata), 32'(8'h10 + i));
      check("burst_rdcnt", 32'(rd_count), exp_rd);
    end
    step(1'b0, 1'b0, 4'd0, 8'h00);
    check("burst_end_ready", 32'(ready), 32'd0);

    step(1'b1, 1'b1, 4'd13, 8'hFF);
    check("oor_wr_ready", 32'(ready), 32'd1);
    check("oor_wr_err", 32'(err), 32'd1);
    check("oor_wr_wrcnt", 32'(wr_count), 32'd5);
    check("oor_wr_rdata", 32'(rdata), 32'h13);
    step(1'b1, 1'b0, 4'd13, 8'h00);
    check("oor_rd_err", 32'(err), 32'd1);
    check("oor_rd_rdata", 32'(rdata), 32'd0);
    check("oor_rd_rdcnt", 32'(rd_count), 32'd6);
    step(1'b1, 1'b0, 4'd11, 8'h00);
    check("edge_rd_err", 32'(err), 32'd0);
    check("edge_rd_rdata", 32'(rdata), 32'd0);
    check("edge_rd_rdcnt", 32'(rd_count), 32'd7);
    step(1'b1, 1'b0, 4'd12, 8'h00);
    check("depth_rd_err", 32'(err), 32'd1);
    step(1'b0, 1'b0, 4'd0, 8'h00);
    check("oor_idle_err", 32'(err), 32'd0);

    step(1'b1, 1'b1, 4'd4, 8'h5A);
    check("mid_wr_ready", 32'(ready), 32'd1);
    res = 1'b1;
    #1;
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_wrcnt", 32'(wr_count), 32'd0);
    check("mid_rst_rdcnt", 32'(rd_count), 32'd0);
    @(posedge clk);
    #1;
    res = 1'b0;
    step(1'b1, 1'b0, 4'd4, 8'h00);
    check("post_rst_rd4", 32'(rdata), 32'd0);
    step(1'b1, 1'b0, 4'd2, 8'h00);
    check("post_rst_rd2", 32'(rdata), 32'd0);
    check("post_rst_rdcnt", 32'(rd_count), 32'd2);

    exp_wr = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 4'(i % 12), 8'(i));
      if (exp_wr < 15) exp_wr++;
      check("sat_wrcnt", 32'(wr_count), exp_wr);
    end
    step(1'b1, 1'b0, 4'd7, 8'h00);
    check("sat_rd_rdata", 32'(rdata), 32'd19);
    check("sat_hold_wrcnt", 32'(wr_count), 32'd15);
    step(1'b0, 1'b0, 4'd0, 8'h00);
    check("final_ready", 32'(ready), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
